seq_transport_ctrl: RTL and testbench

- Transport and pattern controller for the step-sequencer datapath.
- Holds an 8-entry step-value bank, programmed through a simple write port.
- Steps through 1..8 active steps at a programmable tick length, with run/pause, external sync restart and a per-step gate.
- Drives an oscillator/VCA chain: sigOut feeds pitch or level, gate feeds the envelope.

---
 rtl/seq_transport_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_transport_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_transport_ctrl.sv
// Step-sequencer transport and pattern controller.
// 8-entry step bank, tick counter, run/pause FSM, sync restart and per-step gate.

`ifndef BITS
`define BITS 16
`endif

module seq_transport_ctrl #(
    parameter int STEPS = 8,
    parameter int LENW  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    sync,
    input  logic                    wr_en,
    input  logic [2:0]              wr_addr,
    input  logic signed [`BITS-1:0] wr_data,
    input  logic [3:0]              num_steps,
    input  logic [LENW-1:0]         len,
    input  logic [LENW-1:0]         gate_len,
    output logic signed [`BITS-1:0] sigOut,
    output logic                    gate,
    output logic [2:0]              step_idx,
    output logic                    step_strobe
);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_count;
    logic                    w_resume;

    logic [LENW-1:0]         r_cnt;
    logic [2:0]              r_step;
    logic                    r_strobe;
    logic                    r_gate;
    logic signed [`BITS-1:0] r_sig;
    logic signed [`BITS-1:0] r_bank [STEPS];

    logic [2:0]              w_last;
    logic                    w_wrap;
    logic [2:0]              w_step_nx;

    // Transport state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PAUSE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; a transition cycle neither counts nor gates.
    always_comb begin
        w_next   = r_state;
        w_count  = 1'b0;
        w_resume = 1'b0;
        unique case (r_state)
            PAUSE: begin
                if (run) begin
                    w_next   = RUN;
                    w_resume = 1'b1;
                end
            end
            RUN: begin
                if (run) begin
                    w_count = 1'b1;
                end else begin
                    w_next = PAUSE;
                end
            end
        endcase
    end

    // Last active step index: 0 steps acts as 1, above 8 acts as 8.
    always_comb begin
        w_last = 3'd0;
        if (num_steps == 4'd0) begin
            w_last = 3'd0;
        end else if (num_steps > 4'd8) begin
            w_last = 3'd7;
        end else begin
            w_last = 3'(num_steps - 4'd1);
        end
    end

    assign w_wrap    = (r_cnt == len);
    assign w_step_nx = (r_step >= w_last) ? 3'd0 : r_step + 3'd1;

    // Tick counter, step index, step strobe and gate; sync wins over wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_step   <= '0;
            r_strobe <= 1'b0;
            r_gate   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_gate   <= 1'b0;
            if (w_count) begin
                r_gate <= (r_cnt < gate_len);
                if (w_wrap) begin
                    r_cnt    <= '0;
                    r_step   <= w_step_nx;
                    r_strobe <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_resume) begin
                r_strobe <= 1'b1;
            end
            if (sync) begin
                r_cnt  <= '0;
                r_step <= '0;
                if (r_state == RUN) begin
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    // Step-value bank, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (wr_en) begin
            r_bank[wr_addr] <= wr_data;
        end
    end

    // Output sample follows the current step one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else begin
            r_sig <= r_bank[r_step];
        end
    end

    assign sigOut      = r_sig;
    assign gate        = r_gate;
    assign step_idx    = r_step;
    assign step_strobe = r_strobe;

endmodule

// File: tb/tb_seq_transport_ctrl.sv
// Bench for seq_transport_ctrl: vector table plus directed sequences,
// expected outputs queued at drive time and popped after each clock edge.

`ifndef BITS
`define BITS 16
`endif

module tb_seq_transport_ctrl;

    localparam int LENW = 24;
    localparam int W    = `BITS;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   run = 1'b0;
    logic                   sync = 1'b0;
    logic                   wr_en = 1'b0;
    logic [2:0]             wr_addr = '0;
    logic signed [W-1:0]    wr_data = '0;
    logic [3:0]             num_steps = '0;
    logic [LENW-1:0]        len = '0;
    logic [LENW-1:0]        gate_len = '0;
    logic signed [W-1:0]    sigOut;
    logic                   gate;
    logic [2:0]             step_idx;
    logic                   step_strobe;

    typedef struct {
        int sig;
        bit gate;
        int step;
        bit strobe;
    } exp_t;

    typedef struct {
        bit   run;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_transport_ctrl #(
        .STEPS(8),
        .LENW (LENW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sync       (sync),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .num_steps  (num_steps),
        .len        (len),
        .gate_len   (gate_len),
        .sigOut     (sigOut),
        .gate       (gate),
        .step_idx   (step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(int s, bit g, int st, bit sb_);
        exp_t e;
        e.sig    = s;
        e.gate   = g;
        e.step   = st;
        e.strobe = sb_;
        return e;
    endfunction

    function automatic vec_t mk(bit r, int s, bit g, int st, bit sb_);
        vec_t v;
        v.run = r;
        v.e   = ex(s, g, st, sb_);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".sigOut"}, int'(sigOut), e.sig);
        chk({tag, ".gate"}, int'(gate), int'(e.gate));
        chk({tag, ".step_idx"}, int'(step_idx), e.step);
        chk({tag, ".step_strobe"}, int'(step_strobe), int'(e.strobe));
    endtask

    // Queue the expectation, clock once, pop and compare.
    task automatic tick(input string tag, input exp_t e);
        exp_t got_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        chk_all(tag, got_e);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all(tag, ex(0, 1'b0, 0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Test 1 + 3: run pattern, then pause at step 2 and resume.
        tbl.push_back(mk(1, 10, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 1));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 0, 1, 0));
        tbl.push_back(mk(1, 20, 0, 2, 1));
        tbl.push_back(mk(1, 30, 1, 2, 0));
        tbl.push_back(mk(1, 30, 1, 2, 0));
        tbl.push_back(mk(1, 30, 0, 2, 0));
        tbl.push_back(mk(1, 30, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 1));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 0, 1, 0));
        tbl.push_back(mk(1, 20, 0, 2, 1));
        tbl.push_back(mk(1, 30, 1, 2, 0));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(0, 30, 0, 2, 0));
        end
        tbl.push_back(mk(1, 30, 0, 2, 1));
        tbl.push_back(mk(1, 30, 1, 2, 0));
        tbl.push_back(mk(1, 30, 0, 2, 0));
        tbl.push_back(mk(1, 30, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 1));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 1, 1, 0));
        tbl.push_back(mk(1, 20, 0, 1, 0));

        #1;
        rst = 1'b1;
        #2;
        chk_all("por", ex(0, 1'b0, 0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 16'sd10;
        tick("wr0", ex(0, 1'b0, 0, 1'b0));
        wr_addr = 3'd1;
        wr_data = 16'sd20;
        tick("wr1", ex(10, 1'b0, 0, 1'b0));
        wr_addr = 3'd2;
        wr_data = 16'sd30;
        tick("wr2", ex(10, 1'b0, 0, 1'b0));
        wr_en = 1'b0;
        tick("idle", ex(10, 1'b0, 0, 1'b0));

        num_steps = 4'd3;
        len       = 24'd3;
        gate_len  = 24'd2;
        for (int i = 0; i < tbl.size(); i++) begin
            run = tbl[i].run;
            tick($sformatf("tbl[%0d]", i), tbl[i].e);
        end

        // Test 4: sync on the wrap cycle at step 1 goes to step 0.
        sync = 1'b1;
        tick("sync_wrap", ex(20, 1'b0, 0, 1'b1));
        sync = 1'b0;
        tick("sync_after", ex(10, 1'b1, 0, 1'b0));

        // Test 5: write current step; visible two cycles later.
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = -16'sd5;
        tick("wrcur0", ex(10, 1'b1, 0, 1'b0));
        wr_en = 1'b0;
        tick("wrcur1", ex(-5, 1'b0, 0, 1'b0));
        tick("wrcur2", ex(-5, 1'b0, 1, 1'b1));
        tick("wrcur3", ex(20, 1'b1, 1, 1'b0));

        // Test 6: async reset mid-step with gate high.
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", ex(0, 1'b0, 0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        tick("rs1", ex(0, 1'b0, 0, 1'b1));
        tick("rs2", ex(0, 1'b1, 0, 1'b0));
        tick("rs3", ex(0, 1'b1, 0, 1'b0));
        tick("rs4", ex(0, 1'b0, 0, 1'b0));
        tick("rs5", ex(0, 1'b0, 1, 1'b1));
        tick("rs6", ex(0, 1'b1, 1, 1'b0));

        // Test 2: num_steps=0, len=0, gate_len=0.
        run = 1'b0;
        do_reset("rst2");
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 16'sd7;
        tick("t2wr0", ex(0, 1'b0, 0, 1'b0));
        wr_addr = 3'd1;
        wr_data = 16'sd99;
        tick("t2wr1", ex(7, 1'b0, 0, 1'b0));
        wr_en = 1'b0;
        tick("t2idle", ex(7, 1'b0, 0, 1'b0));
        num_steps = 4'd0;
        len       = 24'd0;
        gate_len  = 24'd0;
        run       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick($sformatf("n0[%0d]", i), ex(7, 1'b0, 0, 1'b1));
        end

        // num_steps above 8 acts as 8: full 0..7 wrap.
        num_steps = 4'd12;
        for (int k = 1; k <= 9; k++) begin
            int prev;
            int es;
            prev = (k - 1) % 8;
            es   = (prev == 0) ? 7 : ((prev == 1) ? 99 : 0);
            tick($sformatf("n12[%0d]", k), ex(es, 1'b0, k % 8, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
